trap_controller: RTL and testbench

- Pipeline-side trap sequencer that drives the CSR register file's trap inputs (exception_pending, m_cause, pc_exc, instruction_word, m_ret/s_ret/u_ret).
- Consumes the CSR file's gated interrupt enables, mtvec_out and current_mode.
- Arbitrates synchronous exceptions, xRET and synchronized interrupt lines for the instruction in execute. Issues a one-cycle trap commit, then flushes the pipeline and redirects fetch.

---
 rtl/trap_controller.sv | 147 ++++++++++++++
 tb/tb_trap_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Trap sequencer: arbitrates interrupts, exceptions and xRET for the execute
// instruction, strobes a one-cycle commit to the CSR file, then flushes/redirects.
module trap_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ex_valid,
  input  logic        stall,
  input  logic [31:0] ex_pc,
  input  logic [29:0] ex_instr,
  input  logic        ex_exc,
  input  logic [4:0]  ex_exc_code,
  input  logic        ex_mret,
  input  logic        ex_sret,
  input  logic        m_ext_irq,
  input  logic        m_tmr_irq,
  input  logic        s_ext_irq,
  input  logic        s_tmr_irq,
  input  logic        m_eie,
  input  logic        m_tie,
  input  logic        s_eie,
  input  logic        s_tie,
  input  logic [1:0]  current_mode,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  input  logic [31:0] sepc_in,
  output logic        exception_pending,
  output logic [31:0] m_cause,
  output logic [31:0] pc_exc,
  output logic [29:0] instruction_word,
  output logic        m_ret,
  output logic        s_ret,
  output logic        u_ret,
  output logic        flush,
  output logic        stall_req,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_FLUSH} state_t;
  typedef enum logic [1:0] {K_TRAP, K_MRET, K_SRET} kind_t;

  state_t                       r_state, w_next;
  kind_t                        r_kind, w_kind;
  logic [SYNC_STAGES-1:0][3:0]  r_sync;
  logic [3:0]                   w_irq;
  logic                         w_event, w_accept;
  logic [31:0]                  w_cause, r_cause, r_pc;
  logic [29:0]                  r_instr;
  logic [CW-1:0]                r_cnt;
  logic [31:0]                  w_target;

  // Bit order in every 4-bit irq vector: {MEI, MTI, SEI, STI}.
  // NOTE: every flop is written with <= so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], {m_ext_irq, m_tmr_irq, s_ext_irq, s_tmr_irq}};
  end

  assign w_irq = r_sync[SYNC_STAGES-1] & {m_eie, m_tie, s_eie, s_tie};

  // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    w_event = 1'b1;
    w_kind  = K_TRAP;
    w_cause = r_cause;
    if      (w_irq[3])                          w_cause = {1'b1, 26'b0, 5'd11};
    else if (w_irq[2])                          w_cause = {1'b1, 26'b0, 5'd7};
    else if (w_irq[1])                          w_cause = {1'b1, 26'b0, 5'd9};
    else if (w_irq[0])                          w_cause = {1'b1, 26'b0, 5'd5};
    else if (ex_exc)                            w_cause = {27'b0, ex_exc_code};
    else if (ex_mret && current_mode != 2'd3)   w_cause = 32'd2;
    else if (ex_sret && current_mode == 2'd0)   w_cause = 32'd2;
    else if (ex_mret)                           w_kind  = K_MRET;
    else if (ex_sret)                           w_kind  = K_SRET;
    else                                        w_event = 1'b0;
  end

  assign w_accept = (r_state == S_IDLE) && ex_valid && !stall && w_event;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_TRAP;
      S_TRAP:  w_next = S_FLUSH;
      S_FLUSH: if (r_cnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_kind  <= K_TRAP;
      r_cause <= '0;
      r_pc    <= '0;
      r_instr <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_kind  <= w_kind;
        r_cause <= w_cause;
        r_pc    <= ex_pc;
        r_instr <= ex_instr;
      end
      if (r_state == S_TRAP)                       r_cnt <= CW'(FLUSH_CYCLES - 1);
      else if (r_state == S_FLUSH && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
    end
  end

  // Redirect targets are taken live in the TRAP cycle, not captured at accept.
  always_comb begin
    unique case (r_kind)
      K_MRET:  w_target = mepc_in;
      K_SRET:  w_target = sepc_in;
      default: w_target = mtvec_in;
    endcase
  end

  always_comb begin
    exception_pending = 1'b0;
    redirect_valid    = 1'b0;
    m_ret             = 1'b0;
    s_ret             = 1'b0;
    redirect_pc       = '0;
    if (r_state == S_TRAP) begin
      exception_pending = 1'b1;
      redirect_valid    = 1'b1;
      m_ret             = (r_kind == K_MRET);
      s_ret             = (r_kind == K_SRET);
      redirect_pc       = {w_target[31:2], 2'b00};
    end
  end

  assign flush            = (r_state != S_IDLE);
  assign stall_req        = (r_state != S_IDLE);
  assign u_ret            = 1'b0;
  assign m_cause          = r_cause;
  assign pc_exc           = r_pc;
  assign instruction_word = r_instr;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: a cycle-level reference model queues
// expected commits; a negedge monitor pops and compares them.
module tb_trap_controller;

  localparam int FC = 2;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ex_valid, stall, ex_exc, ex_mret, ex_sret;
  logic [31:0] ex_pc;
  logic [29:0] ex_instr;
  logic [4:0]  ex_exc_code;
  logic        m_ext_irq, m_tmr_irq, s_ext_irq, s_tmr_irq;
  logic        m_eie, m_tie, s_eie, s_tie;
  logic [1:0]  current_mode;
  logic [31:0] mtvec_in, mepc_in, sepc_in;

  logic        exception_pending, m_ret, s_ret, u_ret, flush, stall_req, redirect_valid;
  logic [31:0] m_cause, pc_exc, redirect_pc;
  logic [29:0] instruction_word;

  trap_controller #(.FLUSH_CYCLES(FC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .nrst(nrst), .ex_valid(ex_valid), .stall(stall), .ex_pc(ex_pc),
    .ex_instr(ex_instr), .ex_exc(ex_exc), .ex_exc_code(ex_exc_code),
    .ex_mret(ex_mret), .ex_sret(ex_sret),
    .m_ext_irq(m_ext_irq), .m_tmr_irq(m_tmr_irq), .s_ext_irq(s_ext_irq), .s_tmr_irq(s_tmr_irq),
    .m_eie(m_eie), .m_tie(m_tie), .s_eie(s_eie), .s_tie(s_tie),
    .current_mode(current_mode), .mtvec_in(mtvec_in), .mepc_in(mepc_in), .sepc_in(sepc_in),
    .exception_pending(exception_pending), .m_cause(m_cause), .pc_exc(pc_exc),
    .instruction_word(instruction_word), .m_ret(m_ret), .s_ret(s_ret), .u_ret(u_ret),
    .flush(flush), .stall_req(stall_req), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cause;
    logic [31:0] pc;
    logic [29:0] instr;
    int          kind;   // 0 trap, 1 MRET, 2 SRET
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: decides at each rising edge what the controller must do.
  logic [3:0]  hist[$];
  int          busy;
  bit          exp_commit, exp_flush;
  logic [31:0] last_cause;
  int          code_of_bit[4] = '{5, 9, 7, 11};

  always @(posedge clk) begin : model
    logic [3:0] vis, pend;
    exp_t       e;
    bit         ev;
    if (!nrst) begin
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(4'b0);
      busy = 0; exp_commit = 0; exp_flush = 0; last_cause = '0;
    end else begin
      vis = hist.pop_front();
      hist.push_back({m_ext_irq, m_tmr_irq, s_ext_irq, s_tmr_irq});
      exp_commit = 0;
      if (busy > 0) busy--;
      else if (ex_valid && !stall) begin
        pend = vis & {m_eie, m_tie, s_eie, s_tie};
        ev = 1; e.pc = ex_pc; e.instr = ex_instr; e.kind = 0; e.cause = last_cause;
        if (pend != 4'b0) begin
          for (int i = 0; i < 4; i++)
            if (pend[i]) e.cause = 32'h8000_0000 | 32'(code_of_bit[i]);
        end
        else if (ex_exc)                                 e.cause = {27'b0, ex_exc_code};
        else if ((ex_mret && current_mode != 2'd3) ||
                 (ex_sret && current_mode == 2'd0))      e.cause = 32'd2;
        else if (ex_mret)                                e.kind = 1;
        else if (ex_sret)                                e.kind = 2;
        else                                             ev = 0;
        if (ev) begin
          if (e.kind == 0) last_cause = e.cause;
          e.cause = last_cause;
          sb.push_back(e);
          busy = 1 + FC;
          exp_commit = 1;
        end
      end
      exp_flush = (busy != 0);
    end
  end

  // Monitor: compares on the falling edge, away from the active edge.
  logic [31:0] hold_cause, hold_pc;
  logic [29:0] hold_instr;

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] tgt;
    if (!nrst) begin
      hold_cause = '0; hold_pc = '0; hold_instr = '0;
    end else begin
      check("exception_pending", {31'b0, exception_pending}, {31'b0, exp_commit});
      check("redirect_valid", {31'b0, redirect_valid}, {31'b0, exp_commit});
      check("flush", {31'b0, flush}, {31'b0, exp_flush});
      check("stall_req", {31'b0, stall_req}, {31'b0, exp_flush});
      check("u_ret", {31'b0, u_ret}, 32'd0);
      if (exception_pending) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_commit actual=commit required=none m_cause=0x%08h", m_cause);
        end else begin
          e = sb.pop_front();
          hold_cause = e.cause; hold_pc = e.pc; hold_instr = e.instr;
          tgt = (e.kind == 1) ? mepc_in : (e.kind == 2) ? sepc_in : mtvec_in;
          check("m_cause", m_cause, e.cause);
          check("pc_exc", pc_exc, e.pc);
          check("instruction_word", {2'b0, instruction_word}, {2'b0, e.instr});
          check("m_ret", {31'b0, m_ret}, (e.kind == 1) ? 32'd1 : 32'd0);
          check("s_ret", {31'b0, s_ret}, (e.kind == 2) ? 32'd1 : 32'd0);
          check("redirect_pc", redirect_pc, tgt & 32'hFFFF_FFFC);
        end
      end else begin
        check("m_ret_idle", {31'b0, m_ret}, 32'd0);
        check("s_ret_idle", {31'b0, s_ret}, 32'd0);
        check("m_cause_hold", m_cause, hold_cause);
        check("pc_exc_hold", pc_exc, hold_pc);
        check("instr_hold", {2'b0, instruction_word}, {2'b0, hold_instr});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_event();
    ex_valid = 0; ex_exc = 0; ex_mret = 0; ex_sret = 0; stall = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_exception_pending"}, {31'b0, exception_pending}, 32'd0);
    check({tag, "_m_cause"}, m_cause, 32'd0);
    check({tag, "_pc_exc"}, pc_exc, 32'd0);
    check({tag, "_instruction_word"}, {2'b0, instruction_word}, 32'd0);
    check({tag, "_rets"}, {29'b0, m_ret, s_ret, u_ret}, 32'd0);
    check({tag, "_flush_stall"}, {30'b0, flush, stall_req}, 32'd0);
    check({tag, "_redirect_valid"}, {31'b0, redirect_valid}, 32'd0);
    check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
  endtask

  initial begin
    nrst = 0;
    clear_event();
    ex_pc = '0; ex_instr = '0; ex_exc_code = '0;
    {m_ext_irq, m_tmr_irq, s_ext_irq, s_tmr_irq} = '0;
    {m_eie, m_tie, s_eie, s_tie} = '0;
    current_mode = 2'd3;
    mtvec_in = '0; mepc_in = '0; sepc_in = '0;
    step(3);
    check_all_zero("reset");
    nrst = 1;
    step(1);

    // Illegal instruction exception
    ex_valid = 1; ex_exc = 1; ex_exc_code = 5'd2; ex_pc = 32'h100; ex_instr = 30'h1234;
    mtvec_in = 32'h200;
    step(1); clear_event(); step(5);

    // Machine timer interrupt through the synchronizer
    m_tmr_irq = 1; m_tie = 1; ex_valid = 1; ex_pc = 32'h400;
    step(4); m_tmr_irq = 0; m_tie = 0; clear_event(); step(6);

    // MEI and STI together: MEI first, STI on a later accept
    m_ext_irq = 1; s_tmr_irq = 1; m_eie = 1; s_tie = 1; ex_valid = 1; ex_pc = 32'h500;
    step(4); m_ext_irq = 0; step(4);
    s_tmr_irq = 0; clear_event(); step(8);
    {m_eie, s_tie} = '0;

    // Legal MRET in M mode
    ex_valid = 1; ex_mret = 1; current_mode = 2'd3; mepc_in = 32'h802; ex_pc = 32'h600;
    step(1); clear_event(); step(4);

    // MRET from U mode and SRET from U mode are illegal
    ex_valid = 1; ex_mret = 1; current_mode = 2'd0; ex_pc = 32'h700;
    step(1); clear_event(); step(4);
    ex_valid = 1; ex_sret = 1; current_mode = 2'd0; ex_pc = 32'h704;
    step(1); clear_event(); step(4);

    // Legal SRET in S mode, exception beating MRET
    ex_valid = 1; ex_sret = 1; current_mode = 2'd1; sepc_in = 32'h0000_0903;
    step(1); clear_event(); step(4);
    ex_valid = 1; ex_mret = 1; ex_exc = 1; ex_exc_code = 5'd13; current_mode = 2'd3;
    step(1); clear_event(); step(4);

    // Reset in the FLUSH cycle, then a fresh exception
    ex_valid = 1; ex_exc = 1; ex_exc_code = 5'd6; ex_pc = 32'h800;
    step(1); clear_event();
    check("trap_before_reset", {31'b0, exception_pending}, 32'd1);
    step(1);
    check("flush_before_reset", {31'b0, flush}, 32'd1);
    nrst = 0;
    #1;
    check_all_zero("reset_mid_flush");
    step(2);
    nrst = 1;
    ex_valid = 1; ex_exc = 1; ex_exc_code = 5'd4; ex_pc = 32'hA00;
    step(1); clear_event();
    check("cause_after_reset", m_cause, 32'd4);
    step(4);

    // Randomized traffic
    repeat (800) begin
      ex_valid     = ($urandom_range(0, 9) < 7);
      stall        = ($urandom_range(0, 9) < 2);
      ex_exc       = ($urandom_range(0, 3) == 0);
      ex_mret      = ($urandom_range(0, 6) == 0);
      ex_sret      = ($urandom_range(0, 6) == 0);
      ex_exc_code  = 5'($urandom);
      ex_pc        = $urandom;
      ex_instr     = 30'($urandom);
      current_mode = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
      mtvec_in     = $urandom;
      mepc_in      = $urandom;
      sepc_in      = $urandom;
      if ($urandom_range(0, 15) == 0) m_ext_irq = ~m_ext_irq;
      if ($urandom_range(0, 15) == 0) m_tmr_irq = ~m_tmr_irq;
      if ($urandom_range(0, 15) == 0) s_ext_irq = ~s_ext_irq;
      if ($urandom_range(0, 15) == 0) s_tmr_irq = ~s_tmr_irq;
      if ($urandom_range(0, 7) == 0) {m_eie, m_tie, s_eie, s_tie} = 4'($urandom);
      step(1);
    end

    clear_event();
    {m_ext_irq, m_tmr_irq, s_ext_irq, s_tmr_irq} = '0;
    step(12);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
